// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package stall_ctrl_pkg;

   localparam int unsigned StallBus = 6;

   localparam int unsigned StallPC  = 0;
   localparam int unsigned StallIF  = 1;
   localparam int unsigned StallID  = 2;
   localparam int unsigned StallEX  = 3;
   localparam int unsigned StallMEM = 4;
   localparam int unsigned StallWB  = 5;

   typedef logic [StallBus-1:0] stall_t;

   // Each requesting stage holds itself and every stage upstream of it; WB never holds.
   localparam stall_t StallNone    = 6'b000000;
   localparam stall_t StallHoldIf  = 6'b000011;
   localparam stall_t StallHoldId  = 6'b000111;
   localparam stall_t StallHoldEx  = 6'b001111;
   localparam stall_t StallHoldMem = 6'b011111;

   localparam logic FlushEnable  = 1'b1;
   localparam logic FlushDisable = 1'b0;
   localparam logic ResetEnable  = 1'b1;

   typedef enum logic [1:0] {
      FlushIdle   = 2'd0,
      FlushWait   = 2'd1,
      FlushActive = 2'd2
   } flush_state_e;

endpackage

// File: rtl/stall_ctrl_if.sv
// Pipeline-side stall request / stall+flush bus between the stage registers and stall_ctrl.
interface stall_ctrl_if;
   import stall_ctrl_pkg::*;

   logic   if_stall_req;
   logic   id_stall_req;
   logic   ex_stall_req;
   logic   mem_stall_req;
   logic   ex_branch_taken;
   stall_t stall;
   logic   flush;

   modport master (
      output if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_branch_taken,
      input  stall, flush
   );

   modport slave (
      input  if_stall_req, id_stall_req, ex_stall_req, mem_stall_req, ex_branch_taken,
      output stall, flush
   );

endinterface

// File: rtl/stall_ctrl_wdog.sv
// Stall watchdog: saturating count of consecutive PC-hold cycles with a sticky timeout flag.
module stall_wdog
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned WDOG_LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic hold,
   output logic timeout
);

   localparam logic [15:0] LimitW = 16'(WDOG_LIMIT);

   logic [15:0] wd;
   logic [15:0] wd_nxt;

   always_comb begin
      wd_nxt = '0;
      if (hold) begin
         wd_nxt = (wd == 16'hFFFF) ? wd : wd + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == ResetEnable) begin
         wd      <= '0;
         timeout <= 1'b0;
      end else begin
         wd <= wd_nxt;
         if (wd_nxt >= LimitW) begin
            timeout <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, sequences branch flushes, runs a watchdog.
// Optional perf counters (stall_cycles, flush_count) are built only when STALL_PERF_EN is defined.
module stall_ctrl
   import stall_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned WDOG_LIMIT   = 1023
) (
   input  logic         clk,
   input  logic         rst,
   stall_ctrl_if.slave  pipe,
   output logic         stall_timeout,
   output logic [31:0]  stall_cycles,
   output logic [31:0]  flush_count
);

   localparam logic [1:0] CntLoad = 2'(FLUSH_CYCLES - 1);

   flush_state_e state;
   flush_state_e state_nxt;
   logic [1:0]   cnt;
   logic [1:0]   cnt_nxt;
   stall_t       base_stall;
   stall_t       stall_vec;
   logic         accept;

   always_comb begin
      base_stall = StallNone;
      if (pipe.mem_stall_req) begin
         base_stall = StallHoldMem;
      end else if (pipe.ex_stall_req) begin
         base_stall = StallHoldEx;
      end else if (pipe.id_stall_req) begin
         base_stall = StallHoldId;
      end else if (pipe.if_stall_req) begin
         base_stall = StallHoldIf;
      end
   end

   // PC must not advance while the wrong-path fetch drains, even once IF stops requesting.
   always_comb begin
      stall_vec = base_stall;
      if (state == FlushWait) begin
         stall_vec = base_stall | StallHoldIf;
      end
   end

   assign pipe.stall = stall_vec;
   assign accept     = pipe.ex_branch_taken & ~stall_vec[StallEX];
   assign pipe.flush = (state == FlushActive) ? FlushEnable : FlushDisable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst == ResetEnable) begin
         state <= FlushIdle;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         FlushIdle: begin
            if (accept) begin
               if (pipe.if_stall_req) begin
                  state_nxt = FlushWait;
               end else begin
                  state_nxt = FlushActive;
                  cnt_nxt   = CntLoad;
               end
            end
         end
         FlushWait: begin
            if (!pipe.if_stall_req) begin
               state_nxt = FlushActive;
               cnt_nxt   = CntLoad;
            end
         end
         FlushActive: begin
            if (accept) begin
               cnt_nxt = CntLoad;
            end else if (cnt == 2'd0) begin
               state_nxt = FlushIdle;
            end else begin
               cnt_nxt = cnt - 2'd1;
            end
         end
         default: state_nxt = FlushIdle;
      endcase
   end

   stall_wdog #(
      .WDOG_LIMIT(WDOG_LIMIT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .hold    (stall_vec[StallPC]),
      .timeout (stall_timeout)
   );

`ifdef STALL_PERF_EN
   logic enter_flush;

   // Only entries from IDLE/WAIT count; a reload while already flushing does not.
   assign enter_flush = (state != FlushActive) && (state_nxt == FlushActive);

   always_ff @(posedge clk or posedge rst) begin
      if (rst == ResetEnable) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_vec[StallPC]) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (enter_flush) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif

endmodule
